// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory read arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ          = 2;
  localparam int READ_LATENCY_DEF = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/mem_read_arbiter_read_tag_pipe.sv
// Delay line of {valid, requester id} that tracks reads in flight through the memory.
module read_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = READ_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    // NOTE: every stage is reset, unlike a data RAM: a stale valid tag would emit a bogus response.
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory read port between two requesters.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = READ_LATENCY_DEF  // legal range 1..8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   rsp_data,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  input  logic [DATA_WIDTH-1:0]                mem_data
);

  logic [NUM_REQ-1:0]                 w_grant;
  req_id_t                            w_grant_id;
  logic                               w_accept;
  tag_t                               w_tag_in;
  tag_t                               w_tag_out;

  req_id_t                            r_last_grant;
  logic [ADDR_WIDTH-1:0]              r_mem_addr;
  logic [NUM_REQ-1:0]                 r_rsp_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] r_rsp_hold;

  always_comb begin
    // NOTE: default assignment first so no path leaves w_grant unassigned (no latch).
    w_grant = '0;
    if (!rst) begin
      if (&req_valid) begin
        if (r_last_grant == 1'b1) w_grant = 2'b01;
        else                      w_grant = 2'b10;
      end else begin
        w_grant = req_valid;
      end
    end
  end

  assign w_accept   = |w_grant;
  assign w_grant_id = w_grant[1];
  assign w_tag_in   = '{valid: w_accept, id: w_grant_id};
  assign req_ready  = w_grant;

  read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_last_grant <= 1'b1;
      r_mem_addr   <= '0;
      r_rsp_valid  <= '0;
      r_rsp_hold   <= '0;
    end else begin
      if (w_accept) begin
        r_mem_addr   <= req_addr[w_grant_id];
        r_last_grant <= w_grant_id;
      end
      r_rsp_valid <= '0;
      if (w_tag_out.valid) r_rsp_valid[w_tag_out.id] <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_rsp_valid[i]) r_rsp_hold[i] <= mem_data;
      end
    end
  end

  // Memory data is live only in the response cycle; otherwise the captured copy is shown.
  always_comb begin
    rsp_data = r_rsp_hold;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_rsp_valid[i]) rsp_data[i] = mem_data;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench: three builds (latency 2, 1, 8) driven in lockstep against a memory model mem[a] = a ^ 8'hA5.
module tb_mem_read_arbiter;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0][7:0]      req_addr;

  logic [1:0]           rdy [3];
  logic [1:0]           rv  [3];
  logic [1:0][7:0]      rd  [3];
  logic [7:0]           ma  [3];
  logic [7:0]           md  [3];

  logic [7:0]           mem [256];

  int errors = 0;
  int checks = 0;
  int n      = 0;

  logic                 sv     [3][16];
  logic                 sid    [3][16];
  logic [7:0]           sd     [3][16];
  logic [7:0]           last_d [3][2];
  logic [7:0]           exp_ma;
  logic                 rr_last;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : 8;
    logic [7:0] mp [8];

    mem_read_arbiter #(
      .ADDR_WIDTH   (8),
      .DATA_WIDTH   (8),
      .READ_LATENCY (L)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (rdy[k]),
      .rsp_valid (rv[k]),
      .rsp_data  (rd[k]),
      .mem_addr  (ma[k]),
      .mem_data  (md[k])
    );

    always @(posedge clk) begin
      mp[0] <= mem[ma[k]];
      for (int j = 1; j < 8; j++) mp[j] <= mp[j-1];
    end
    assign md[k] = mp[L-1];
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lat%0d cycle%0d observed=%h expected=%h", tag, lat_of(k), n, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b11;
    req_addr  = {8'h77, 8'h66};
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("ready_in_reset", k, {30'd0, rdy[k]}, 32'd0);
      for (int s = 0; s < 16; s++) begin
        sv[k][s]  = 1'b0;
        sid[k][s] = 1'b0;
        sd[k][s]  = 8'h00;
      end
      last_d[k][0] = 8'h00;
      last_d[k][1] = 8'h00;
    end
    exp_ma  = 8'h00;
    rr_last = 1'b1;
    n++;
  endtask

  task automatic cycle(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [1:0] exp_rdy);
    int         slot;
    logic [1:0] ev;
    logic       id;
    logic [7:0] addr;
    @(negedge clk);
    rst         = 1'b0;
    req_valid   = v;
    req_addr[0] = a0;
    req_addr[1] = a1;
    #1;
    slot = n % 16;
    for (int k = 0; k < 3; k++) begin
      chk("req_ready", k, {30'd0, rdy[k]}, {30'd0, exp_rdy});
      chk("mem_addr", k, {24'd0, ma[k]}, {24'd0, exp_ma});
      ev = sv[k][slot] ? (sid[k][slot] ? 2'b10 : 2'b01) : 2'b00;
      chk("rsp_valid", k, {30'd0, rv[k]}, {30'd0, ev});
      if (sv[k][slot]) last_d[k][sid[k][slot]] = sd[k][slot];
      chk("rsp_data0", k, {24'd0, rd[k][0]}, {24'd0, last_d[k][0]});
      chk("rsp_data1", k, {24'd0, rd[k][1]}, {24'd0, last_d[k][1]});
      sv[k][slot] = 1'b0;
    end
    if (exp_rdy != 2'b00) begin
      id   = exp_rdy[1];
      addr = id ? a1 : a0;
      for (int k = 0; k < 3; k++) begin
        slot         = (n + 1 + lat_of(k)) % 16;
        sv[k][slot]  = 1'b1;
        sid[k][slot] = id;
        sd[k][slot]  = addr ^ 8'hA5;
      end
      exp_ma  = addr;
      rr_last = id;
    end
    n++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(2'b00, 8'h00, 8'h00, 2'b00);
  endtask

  initial begin
    logic [1:0] v;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [1:0] e;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = '0;
    repeat (2) @(posedge clk);

    do_reset();
    idle(2);

    // Both requesters held: alternate 0,1,0,1 starting with requester 0.
    cycle(2'b11, 8'h10, 8'h20, 2'b01);
    cycle(2'b11, 8'h10, 8'h20, 2'b10);
    cycle(2'b11, 8'h10, 8'h20, 2'b01);
    cycle(2'b11, 8'h10, 8'h20, 2'b10);
    idle(10);

    // Sole requester 1, single cycle.
    cycle(2'b10, 8'h00, 8'h05, 2'b10);
    idle(10);

    // Two acceptances (1 then 0), reset in the following cycle: no responses, tie back to 0.
    cycle(2'b10, 8'h00, 8'h40, 2'b10);
    cycle(2'b01, 8'h30, 8'h00, 2'b01);
    do_reset();
    idle(10);
    cycle(2'b11, 8'h50, 8'h60, 2'b01);
    idle(10);

    // Back-to-back mixed acceptances.
    cycle(2'b01, 8'h01, 8'h02, 2'b01);
    cycle(2'b10, 8'h03, 8'h04, 2'b10);
    cycle(2'b11, 8'hFE, 8'hFF, 2'b01);
    cycle(2'b11, 8'hFE, 8'hFF, 2'b10);
    cycle(2'b10, 8'h00, 8'h80, 2'b10);
    cycle(2'b01, 8'h7F, 8'h00, 2'b01);
    idle(10);

    // 64 random accepted reads against the preloaded memory.
    for (int i = 0; i < 64; i++) begin
      v  = 2'($urandom_range(1, 3));
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      e  = (v == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : v;
      cycle(v, a0, a1, e);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the width of the user-side memory address.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the width of the user-side memory read data.
REQ-003 SHALL have parameter READ_LATENCY, default 2, the cycles from mem_addr change to valid mem_data; legal range 1..8.
REQ-004 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports: req_valid[i]  input  1  requester i (i=0,1) presents a read.
REQ-007 SHALL have ports: req_addr[i]  input  ADDR_WIDTH  read address of requester i.
REQ-008 SHALL have ports: req_ready[i]  output  1  read of requester i accepted this cycle.
REQ-009 SHALL have ports: rsp_valid[i]  output  1  rsp_data[i] carries requester i's read result.
REQ-010 SHALL have ports: rsp_data[i]  output  DATA_WIDTH  read result for requester i.
REQ-011 SHALL have port: mem_addr  output  ADDR_WIDTH  drives the host-to-FPGA memory user address port.
REQ-012 SHALL have port: mem_data  input  DATA_WIDTH  user data-out of that memory.

Function
REQ-013 SHALL accept at most one read per cycle; acceptance of requester i is the cycle where req_valid[i] and req_ready[i] are both high.
REQ-014 SHALL compute req_ready combinationally from req_valid and the round-robin pointer; req_ready[i] is high only if req_valid[i] is high.
REQ-015 SHALL grant the sole requester when one req_valid is high, with no bubble.
REQ-016 SHALL grant, when both requesters are valid, the requester not granted most recently (round-robin pointer last_grant).
REQ-017 SHALL update last_grant only on an acceptance; idle cycles leave it unchanged.
REQ-018 SHALL register the accepted address into mem_addr on the accepting edge; mem_addr holds its value when no read is accepted.
REQ-019 SHALL assert rsp_valid[i] for exactly one cycle, READ_LATENCY cycles after the mem_addr update, with rsp_data[i] = mem_data sampled in that cycle.
REQ-020 SHALL be fully pipelined: back-to-back acceptances (any mix of requesters) each yield one response, in acceptance order.
REQ-021 SHALL never assert rsp_valid[0] and rsp_valid[1] in the same cycle.
REQ-022 SHALL hold rsp_data[i] at its last value while rsp_valid[i] is low.
REQ-023 SHALL place no backpressure on responses; a requester must accept rsp_valid in the cycle it is asserted.

Reset
REQ-024 SHALL on rst: req_ready=0 for the reset cycle, rsp_valid=0, rsp_data=0, mem_addr=0, last_grant=1 (requester 0 wins the first tie), all in-flight tags cleared.
REQ-025 SHALL produce no response for reads in flight when rst is asserted mid-operation; first rsp_valid after reset is at the earliest READ_LATENCY+1 cycles after the first post-reset acceptance.

Structure
REQ-026 SHALL import package mem_arb_pkg holding the requester-id typedef (1 bit), NUM_REQ=2 and the READ_LATENCY default.
REQ-027 SHALL instantiate one sub-module read_tag_pipe: a READ_LATENCY-deep shift register of {valid, requester id}, cleared by rst, whose output steers mem_data to the selected requester.

Verification
REQ-028 SHALL cover: after reset, req_valid=2'b11, addr0=8'h10, addr1=8'h20 held 4 cycles -> grants 0,1,0,1; mem_addr 10,20,10,20; responses to 0,1,0,1 with memory contents.
REQ-029 SHALL cover: only requester 1 valid, addr 8'h05 for 1 cycle -> req_ready[1]=1 same cycle, mem_addr=05 next edge, rsp_valid[1] exactly READ_LATENCY cycles later with mem[05].
REQ-030 SHALL cover: memory preloaded mem[a]=a^8'hA5, 64 random accepted reads -> every response matches, order preserved, no dual rsp_valid.
REQ-031 SHALL cover: rst asserted 1 cycle after two acceptances -> no rsp_valid for either, mem_addr=0, next tie goes to requester 0.
REQ-032 SHALL cover: READ_LATENCY=1 and READ_LATENCY=8 builds with back-to-back reads -> one response per acceptance at the parameterised delay.
